// File: rtl/core_pkg.sv
// Shared core types: ROB completion bundle and its widths.
// Imported by the writeback arbiter and its holding slots.
package core_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 6;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      result;
    logic                 exc;
  } rob_wb_t;

endpackage

// File: rtl/rob_writeback_arbiter_slot.sv
// One-entry holding register for a single FU result.
// Flush wins over load; load wins over drain (drain+refill).
module rob_wb_slot
  import core_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_i,
  input  logic    drain_i,
  input  logic    flush_i,
  input  rob_wb_t d_i,
  output logic    valid_o,
  output rob_wb_t q_o
);

  logic    valid_q, valid_d;
  rob_wb_t data_q, data_d;

  // Next-state for the occupancy flag and payload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/rob_writeback_arbiter.sv
// Round-robin share of NUM_WB ROB completion ports among NUM_FU slots.
// Optional stall counter enabled by defining ROB_WB_PERF_EN.
module rob_writeback_arbiter
  import core_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int NUM_WB = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_FU-1:0]      fu_valid_i,
  output logic [NUM_FU-1:0]      fu_ready_o,
  input  rob_wb_t [NUM_FU-1:0]   fu_wb_i,
  output logic [NUM_WB-1:0]      wb_valid_o,
  input  logic [NUM_WB-1:0]      wb_ready_i,
  output rob_wb_t [NUM_WB-1:0]   wb_o,
  input  logic                   flush_i
`ifdef ROB_WB_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  localparam int PW = $clog2(NUM_FU);

  logic [PW-1:0]         rr_q, rr_d;
  logic [NUM_FU-1:0]     slot_v;
  logic [NUM_FU-1:0]     drain;
  logic [NUM_FU-1:0]     load;
  rob_wb_t [NUM_FU-1:0]  slot_q;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    rob_wb_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[g]),
      .drain_i (drain[g]),
      .flush_i (flush_i),
      .d_i     (fu_wb_i[g]),
      .valid_o (slot_v[g]),
      .q_o     (slot_q[g])
    );
  end

  logic [PW:0]   sum;
  logic [PW-1:0] sidx;
  int unsigned   cnt;

  // Scan from rr_q; j-th valid slot goes to port j.
  always_comb begin
    wb_valid_o = '0;
    wb_o       = '0;
    drain      = '0;
    rr_d       = rr_q;
    sum        = '0;
    sidx       = '0;
    cnt        = 0;
    for (int o = 0; o < NUM_FU; o++) begin
      sum = {1'b0, rr_q} + (PW+1)'(o);
      if (sum >= (PW+1)'(NUM_FU)) begin
        sum = sum - (PW+1)'(NUM_FU);
      end
      sidx = sum[PW-1:0];
      if (slot_v[sidx] && cnt < NUM_WB) begin
        wb_valid_o[cnt] = 1'b1;
        wb_o[cnt]       = slot_q[sidx];
        if (wb_ready_i[cnt]) begin
          drain[sidx] = 1'b1;
          rr_d = (sidx == PW'(NUM_FU-1)) ?
                 '0 : sidx + 1'b1;
        end
        cnt = cnt + 1;
      end
    end
    if (flush_i) begin
      wb_valid_o = '0;
      drain      = '0;
      rr_d       = '0;
    end
  end

  assign fu_ready_o = {NUM_FU{rst & ~flush_i}}
                    & (~slot_v | drain);
  assign load       = fu_valid_i & fu_ready_o;

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

`ifdef ROB_WB_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall;

  assign stall = (|(slot_v & ~drain)) & ~flush_i;

  // Saturating count of cycles with a held, undrained result.
  always_comb begin
    stall_d = stall_q;
    if (stall && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register; flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_rob_writeback_arbiter.sv
// Self-checking bench for rob_writeback_arbiter (NUM_FU=4, NUM_WB=3).
// Directed vector table, hand sequences, random run vs queue model.
module tb_rob_writeback_arbiter;
  import core_pkg::*;

  localparam int NF = 4;
  localparam int NW = 3;

  logic                clk;
  logic                rst;
  logic [NF-1:0]       fu_valid_i;
  logic [NF-1:0]       fu_ready_o;
  rob_wb_t [NF-1:0]    fu_wb_i;
  logic [NW-1:0]       wb_valid_o;
  logic [NW-1:0]       wb_ready_i;
  rob_wb_t [NW-1:0]    wb_o;
  logic                flush_i;
`ifdef ROB_WB_PERF_EN
  logic [31:0]         stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  rob_writeback_arbiter #(.NUM_FU(NF), .NUM_WB(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fu_valid_i (fu_valid_i),
    .fu_ready_o (fu_ready_o),
    .fu_wb_i    (fu_wb_i),
    .wb_valid_o (wb_valid_o),
    .wb_ready_i (wb_ready_i),
    .wb_o       (wb_o),
    .flush_i    (flush_i)
`ifdef ROB_WB_PERF_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       fv;
    logic [3:0][5:0]  ix;
    logic [2:0]       wr;
    logic             fl;
    logic [2:0]       ewbv;
    logic [3:0]       erdy;
    logic [2:0][5:0]  eix;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic rob_wb_t mk(input logic [5:0] ix);
    rob_wb_t r;
    r.rob_idx = ix;
    r.result  = 32'(ix) * 32'd3;
    r.exc     = ix[0];
    return r;
  endfunction

  task automatic step(input string nm,
                      input logic [3:0] fv,
                      input logic [3:0][5:0] ix,
                      input logic [2:0] wr,
                      input logic fl,
                      input logic [2:0] ewbv,
                      input logic [3:0] erdy,
                      input logic [2:0][5:0] eix);
    fu_valid_i = fv;
    for (int i = 0; i < NF; i++) fu_wb_i[i] = mk(ix[i]);
    wb_ready_i = wr;
    flush_i    = fl;
    #2;
    chk({nm, ".wbv"}, 64'(wb_valid_o), 64'(ewbv));
    chk({nm, ".rdy"}, 64'(fu_ready_o), 64'(erdy));
    for (int k = 0; k < NW; k++) begin
      if (ewbv[k]) begin
        chk($sformatf("%s.p%0d", nm, k),
            64'(wb_o[k]), 64'(mk(eix[k])));
      end
    end
    @(negedge clk);
  endtask

  task automatic run_random();
    logic    mv[NF];
    rob_wb_t md[NF];
    logic    pv[NF];
    rob_wb_t pd[NF];
    int      mrr;
    int      q[$];
    int      last;
    logic [NF-1:0] dr, erdy;
    logic [NW-1:0] ewbv, wr;
    logic    fl;
    logic [31:0] serial;
    serial = 0;
    mrr = 0;
    for (int i = 0; i < NF; i++) begin
      mv[i] = 1'b0; pv[i] = 1'b0;
      md[i] = '0;   pd[i] = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!pv[i]) begin
          pv[i] = ($urandom_range(0, 99) < 60);
          pd[i].rob_idx = 6'($urandom);
          pd[i].result  = serial;
          pd[i].exc     = 1'($urandom);
          serial++;
        end
      end
      wr = 3'($urandom);
      fl = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NF; i++) begin
        fu_valid_i[i] = pv[i];
        fu_wb_i[i]    = pd[i];
      end
      wb_ready_i = wr;
      flush_i    = fl;
      #2;
      q.delete();
      for (int o = 0; o < NF; o++) begin
        if (mv[(mrr + o) % NF]) q.push_back((mrr + o) % NF);
      end
      ewbv = '0; erdy = '0; dr = '0; last = -1;
      if (!fl) begin
        for (int k = 0; k < NW && k < q.size(); k++) begin
          ewbv[k] = 1'b1;
          chk($sformatf("rnd%0d.p%0d", c, k),
              64'(wb_o[k]), 64'(md[q[k]]));
          if (wr[k]) begin
            dr[q[k]] = 1'b1;
            last = q[k];
          end
        end
        for (int i = 0; i < NF; i++) erdy[i] = !mv[i] || dr[i];
      end
      chk($sformatf("rnd%0d.wbv", c),
          64'(wb_valid_o), 64'(ewbv));
      chk($sformatf("rnd%0d.rdy", c),
          64'(fu_ready_o), 64'(erdy));
      if (fl) begin
        for (int i = 0; i < NF; i++) mv[i] = 1'b0;
        mrr = 0;
      end else begin
        for (int i = 0; i < NF; i++) if (dr[i]) mv[i] = 1'b0;
        if (last >= 0) mrr = (last + 1) % NF;
        for (int i = 0; i < NF; i++) begin
          if (pv[i] && erdy[i]) begin
            mv[i] = 1'b1;
            md[i] = pd[i];
            pv[i] = 1'b0;
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b0;
    fu_valid_i = '0;
    fu_wb_i    = '0;
    wb_ready_i = '0;
    flush_i    = 1'b0;
    #1;
    fu_valid_i = 4'b1111;
    #1;
    chk("rst.wbv", 64'(wb_valid_o), 64'd0);
    chk("rst.rdy", 64'(fu_ready_o), 64'd0);
`ifdef ROB_WB_PERF_EN
    chk("rst.cnt", 64'(stall_cnt_o), 64'd0);
`endif
    fu_valid_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    tbl[0] = '{4'b0111, {6'd0, 6'd7, 6'd6, 6'd5}, 3'b111,
               1'b0, 3'b000, 4'b1111, 18'd0};
    tbl[1] = '{4'b0000, 24'd0, 3'b111,
               1'b0, 3'b111, 4'b1111, {6'd7, 6'd6, 6'd5}};
    tbl[2] = '{4'b0000, 24'd0, 3'b111,
               1'b1, 3'b000, 4'b0000, 18'd0};
    tbl[3] = '{4'b1111, {6'd19, 6'd18, 6'd17, 6'd16}, 3'b111,
               1'b0, 3'b000, 4'b1111, 18'd0};
    tbl[4] = '{4'b1111, {6'd23, 6'd22, 6'd21, 6'd20}, 3'b111,
               1'b0, 3'b111, 4'b0111, {6'd18, 6'd17, 6'd16}};
    tbl[5] = '{4'b1111, {6'd27, 6'd26, 6'd25, 6'd24}, 3'b111,
               1'b0, 3'b111, 4'b1011, {6'd21, 6'd20, 6'd19}};
    tbl[6] = '{4'b1111, {6'd31, 6'd30, 6'd29, 6'd28}, 3'b111,
               1'b0, 3'b111, 4'b1101, {6'd24, 6'd27, 6'd22}};
    tbl[7] = '{4'b0000, 24'd0, 3'b111,
               1'b0, 3'b111, 4'b1110, {6'd31, 6'd30, 6'd25}};
    tbl[8] = '{4'b0000, 24'd0, 3'b111,
               1'b0, 3'b001, 4'b1111, {6'd0, 6'd0, 6'd28}};

    for (int n = 0; n < 9; n++) begin
      step($sformatf("row%0d", n), tbl[n].fv, tbl[n].ix,
           tbl[n].wr, tbl[n].fl, tbl[n].ewbv,
           tbl[n].erdy, tbl[n].eix);
    end

    // hold slot 1 while the ROB refuses, then drain once
    step("hold.ld", 4'b0010, {6'd0, 6'd0, 6'd9, 6'd0},
         3'b000, 1'b0, 3'b000, 4'b1111, 18'd0);
    for (int h = 0; h < 3; h++) begin
      step($sformatf("hold%0d", h), 4'b0000, 24'd0,
           3'b000, 1'b0, 3'b001, 4'b1101, {6'd0, 6'd0, 6'd9});
    end
    step("hold.dr", 4'b0000, 24'd0, 3'b001, 1'b0,
         3'b001, 4'b1111, {6'd0, 6'd0, 6'd9});
    step("hold.gone", 4'b0000, 24'd0, 3'b111, 1'b0,
         3'b000, 4'b1111, 18'd0);

    // fill, flush with FU2 valid, then confirm pointer reset
    step("full.ld", 4'b1111, {6'd35, 6'd34, 6'd33, 6'd32},
         3'b000, 1'b0, 3'b000, 4'b1111, 18'd0);
    step("full", 4'b0000, 24'd0, 3'b000, 1'b0,
         3'b111, 4'b0000, {6'd32, 6'd35, 6'd34});
    step("flush", 4'b0100, {6'd0, 6'd50, 6'd0, 6'd0},
         3'b111, 1'b1, 3'b000, 4'b0000, 18'd0);
    step("post.ld", 4'b1111, {6'd43, 6'd42, 6'd41, 6'd40},
         3'b000, 1'b0, 3'b000, 4'b1111, 18'd0);
    step("post.rr", 4'b0000, 24'd0, 3'b000, 1'b0,
         3'b111, 4'b0000, {6'd42, 6'd41, 6'd40});
    step("post.dr", 4'b0000, 24'd0, 3'b011, 1'b0,
         3'b111, 4'b0011, {6'd42, 6'd41, 6'd40});

    // asynchronous reset with two slots still held
    fu_valid_i = 4'b1111;
    #2 rst = 1'b0;
    #1;
    chk("arst.wbv", 64'(wb_valid_o), 64'd0);
    chk("arst.rdy", 64'(fu_ready_o), 64'd0);
    fu_valid_i = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arel.wbv", 64'(wb_valid_o), 64'd0);
    chk("arel.rdy", 64'(fu_ready_o), 64'hF);
    @(negedge clk);

`ifdef ROB_WB_PERF_EN
    chk("cnt.0", 64'(stall_cnt_o), 64'd0);
    step("cnt.ld", 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1},
         3'b000, 1'b0, 3'b000, 4'b1111, 18'd0);
    for (int s = 0; s < 5; s++) begin
      step($sformatf("cnt.s%0d", s), 4'b0000, 24'd0,
           3'b000, 1'b0, 3'b111, 4'b1000,
           {6'd3, 6'd2, 6'd1});
    end
    chk("cnt.5", 64'(stall_cnt_o), 64'd5);
    step("cnt.fl", 4'b0000, 24'd0, 3'b000, 1'b1,
         3'b000, 4'b0000, 18'd0);
    chk("cnt.flush", 64'(stall_cnt_o), 64'd5);
    step("cnt.idle", 4'b0000, 24'd0, 3'b000, 1'b0,
         3'b000, 4'b1111, 18'd0);
    chk("cnt.idle", 64'(stall_cnt_o), 64'd5);
`endif

    #2 rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
